ifft4_sym_ctrl: RTL and testbench
=================================

Name: ifft4_sym_ctrl

Overview:
- Sequencer for the 4-point complex IFFT core.
- Collects a serial stream of frequency-domain samples into 4-sample symbols and presents them in parallel to the core.
- Times the core pipeline latency, captures the 4 time-domain outputs and streams them out serially with a programmable cyclic prefix.
- Sits between the subcarrier mapper and the DAC-side sample FIFO.

Parameters:
- DW, 8, signed sample width per real/imag component.
- CORE_LAT, 2, clock cycles from core input presentation to valid core outputs.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous active-high reset.
- cp_len  in  2  cyclic prefix length 0..3 samples; sampled at LAUNCH.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts an input sample.
- in_re, in_im  in  DW  signed input sample, real/imag.
- core_ce  out  1  clock enable to the IFFT core.
- core_re0..3, core_im0..3  out  DW each  parallel symbol to core (y1..y4 order).
- core_xre0..3, core_xim0..3  in  DW each  core outputs (x1..x4 order).
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_re, out_im  out  DW  serial time-domain sample.
- sym_done  out  1  one-cycle pulse on the last output sample of a symbol.
- sym_cnt  out  16  symbols fully emitted, wraps at 65535 -> 0.

Behaviour:
- Asynchronous reset: state=FILL, fill index=0, wait counter=0, all core_* and out_* data=0, core_ce=0, out_valid=0, sym_done=0, sym_cnt=0. in_ready is 0 while rst is high.
- in_ready = (state==FILL) and not rst, combinational.
- FILL:
  - On in_valid and in_ready, write the sample to slot idx of the core input registers; idx increments.
  - On acceptance with idx==3: idx returns to 0 and the next state is LAUNCH.
  - in_valid low holds state; partial symbols are retained indefinitely.
- LAUNCH (1 cycle):
  - core_ce=1.
  - Latch cp_len into cp_r.
  - Load wait counter with CORE_LAT-1.
  - Next state: WAIT.
- WAIT:
  - core_ce=1 and core inputs held stable.
  - Counter decrements each cycle.
  - When the counter is 0, capture all 8 core outputs into the output buffer, then go to DRAIN; core_ce returns to 0.
  - For CORE_LAT=1 capture occurs in the first WAIT cycle.
  - Total latency: last input accept -> first out_valid = CORE_LAT+2 cycles.
- DRAIN:
  - Emits N = 4+cp_r samples.
  - Emission order is buffer indices 4-cp_r..3, then 0..3 (cyclic prefix = last cp_r samples).
  - out_valid=1 for the whole of DRAIN; out_re/out_im are registered from the buffer at the current read pointer.
  - The read pointer advances only on out_valid and out_ready.
  - out_ready low stalls with data held constant (AXI-stream rules; out_valid never drops while a sample is pending).
  - On the final handshake: sym_done pulses for that cycle, sym_cnt increments, out_valid=0 next cycle, and the state returns to FILL.
- No overlap: input is not accepted during LAUNCH/WAIT/DRAIN. Sustained throughput is one symbol per 4+1+CORE_LAT+(4+cp_len) cycles.
- cp_len changes outside LAUNCH have no effect on the symbol in flight.
- Reset asserted mid-operation aborts immediately: the partial symbol and buffer are discarded, and no sym_done is issued.
- Arithmetic: the controller does no arithmetic on samples; data passes bit-exact from core output to out_re/out_im. The only arithmetic is in counters/pointers (2-bit idx, 3-bit read pointer, wait counter of width clog2(CORE_LAT)+1).

Test Plan:
- Core stub = CORE_LAT-cycle register delay of its inputs. Feed (1,-1),(2,-2),(3,-3),(4,-4) with cp_len=0 and out_ready=1 -> out samples (1,-1),(2,-2),(3,-3),(4,-4). First out_valid 4 cycles after the 4th accept; sym_done on the 4th output; sym_cnt=1.
- Same input with cp_len=2 -> output sequence 3,4,1,2,3,4 (real parts), 6 samples, sym_done on the 6th.
- cp_len=3 at launch, changed to 0 during WAIT -> 7 samples emitted (2,3,4,1,2,3,4).
- Toggle out_ready 1,0,0,1 during DRAIN -> out_re holds the same value during the low cycles; no sample is dropped or duplicated; in_ready stays 0 until the symbol completes.
- Supply 2 samples, idle in_valid for 10 cycles, then 2 more -> one symbol launched containing all 4 samples in order.
- Assert rst in the 3rd DRAIN cycle -> out_valid=0, sym_cnt=0, in_ready=1 after release. A fresh symbol (5,5)…(8,8) then outputs correctly.

Source files
------------

// File: rtl/ifft4_sym_ctrl_if.sv
// Bundle of the stream, core and status signals around the 4-point IFFT sequencer.
// master = the sequencer itself, slave = the surrounding mapper/core/FIFO side.
interface ifft4_sym_ctrl_if #(
  parameter int DW = 8
);
  logic [1:0]           cp_len;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_re, in_im;
  logic                 core_ce;
  logic signed [DW-1:0] core_re0, core_re1, core_re2, core_re3;
  logic signed [DW-1:0] core_im0, core_im1, core_im2, core_im3;
  logic signed [DW-1:0] core_xre0, core_xre1, core_xre2, core_xre3;
  logic signed [DW-1:0] core_xim0, core_xim1, core_xim2, core_xim3;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_re, out_im;
  logic                 sym_done;
  logic [15:0]          sym_cnt;

  modport master (
    input  cp_len, in_valid, in_re, in_im,
           core_xre0, core_xre1, core_xre2, core_xre3,
           core_xim0, core_xim1, core_xim2, core_xim3,
           out_ready,
    output in_ready, core_ce,
           core_re0, core_re1, core_re2, core_re3,
           core_im0, core_im1, core_im2, core_im3,
           out_valid, out_re, out_im, sym_done, sym_cnt
  );

  modport slave (
    output cp_len, in_valid, in_re, in_im,
           core_xre0, core_xre1, core_xre2, core_xre3,
           core_xim0, core_xim1, core_xim2, core_xim3,
           out_ready,
    input  in_ready, core_ce,
           core_re0, core_re1, core_re2, core_re3,
           core_im0, core_im1, core_im2, core_im3,
           out_valid, out_re, out_im, sym_done, sym_cnt
  );
endinterface

// File: rtl/ifft4_sym_ctrl.sv
// Symbol sequencer for the 4-point IFFT core: serial-to-parallel fill, core latency
// timing, output capture and serial drain with a cyclic prefix of 0..3 samples.
module ifft4_sym_ctrl #(
  parameter int DW       = 8,
  parameter int CORE_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  ifft4_sym_ctrl_if.master bus
);
  localparam int WW = $clog2(CORE_LAT) + 1;
  localparam logic [WW-1:0] WLOAD = WW'(CORE_LAT - 1);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [WW-1:0]        wcnt_q, wcnt_d;
  logic [1:0]           cp_q, cp_d;
  logic [2:0]           rptr_q, rptr_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [DW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [15:0]          sym_cnt_q, sym_cnt_d;
  logic signed [DW-1:0] core_re_q [4];
  logic signed [DW-1:0] core_re_d [4];
  logic signed [DW-1:0] core_im_q [4];
  logic signed [DW-1:0] core_im_d [4];
  logic signed [DW-1:0] buf_re_q [4];
  logic signed [DW-1:0] buf_re_d [4];
  logic signed [DW-1:0] buf_im_q [4];
  logic signed [DW-1:0] buf_im_d [4];
  logic signed [DW-1:0] xre [4];
  logic signed [DW-1:0] xim [4];

  logic       in_ready_c, in_fire, out_fire, last_c;
  logic [1:0] first_idx, next_idx;

  assign xre[0] = bus.core_xre0;
  assign xre[1] = bus.core_xre1;
  assign xre[2] = bus.core_xre2;
  assign xre[3] = bus.core_xre3;
  assign xim[0] = bus.core_xim0;
  assign xim[1] = bus.core_xim1;
  assign xim[2] = bus.core_xim2;
  assign xim[3] = bus.core_xim3;

  assign in_ready_c = (state_q == S_FILL) && !rst;
  assign in_fire    = in_ready_c && bus.in_valid;
  assign out_fire   = out_valid_q && bus.out_ready;
  assign last_c     = rptr_q == ({1'b0, cp_q} + 3'd3);
  // Emission position p maps to buffer index (p - cp) mod 4: the prefix wraps onto the tail.
  assign first_idx  = 2'd0 - cp_q;
  assign next_idx   = rptr_q[1:0] + 2'd1 - cp_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    cp_d        = cp_q;
    rptr_d      = rptr_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    sym_cnt_d   = sym_cnt_q;
    core_re_d   = core_re_q;
    core_im_d   = core_im_q;
    buf_re_d    = buf_re_q;
    buf_im_d    = buf_im_q;
    case (state_q)
      S_FILL: begin
        if (in_fire) begin
          core_re_d[idx_q] = bus.in_re;
          core_im_d[idx_q] = bus.in_im;
          idx_d            = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cp_d    = bus.cp_len;
        wcnt_d  = WLOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == '0) begin
          buf_re_d    = xre;
          buf_im_d    = xim;
          out_re_d    = xre[first_idx];
          out_im_d    = xim[first_idx];
          out_valid_d = 1'b1;
          rptr_d      = '0;
          state_d     = S_DRAIN;
        end else begin
          wcnt_d = wcnt_q - WW'(1);
        end
      end
      default: begin
        if (out_fire) begin
          if (last_c) begin
            out_valid_d = 1'b0;
            sym_cnt_d   = sym_cnt_q + 16'd1;
            state_d     = S_FILL;
          end else begin
            rptr_d   = rptr_q + 3'd1;
            out_re_d = buf_re_q[next_idx];
            out_im_d = buf_im_q[next_idx];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      idx_q       <= '0;
      wcnt_q      <= '0;
      cp_q        <= '0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      sym_cnt_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        core_re_q[i] <= '0;
        core_im_q[i] <= '0;
        buf_re_q[i]  <= '0;
        buf_im_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      cp_q        <= cp_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      sym_cnt_q   <= sym_cnt_d;
      core_re_q   <= core_re_d;
      core_im_q   <= core_im_d;
      buf_re_q    <= buf_re_d;
      buf_im_q    <= buf_im_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.core_ce   = (state_q == S_LAUNCH) || (state_q == S_WAIT);
  assign bus.core_re0  = core_re_q[0];
  assign bus.core_re1  = core_re_q[1];
  assign bus.core_re2  = core_re_q[2];
  assign bus.core_re3  = core_re_q[3];
  assign bus.core_im0  = core_im_q[0];
  assign bus.core_im1  = core_im_q[1];
  assign bus.core_im2  = core_im_q[2];
  assign bus.core_im3  = core_im_q[3];
  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.sym_done  = out_fire && last_c && (state_q == S_DRAIN);
  assign bus.sym_cnt   = sym_cnt_q;
endmodule

// File: tb/tb_ifft4_sym_ctrl.sv
// Bench for ifft4_sym_ctrl: register-delay core stub, transaction-level model of the
// symbol flow checked every cycle, directed scenarios pinned with literal sequences.
module tb_ifft4_sym_ctrl;
  localparam int DW       = 8;
  localparam int CORE_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifft4_sym_ctrl_if #(.DW(DW)) bus ();

  ifft4_sym_ctrl #(.DW(DW), .CORE_LAT(CORE_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Core stub: CORE_LAT-deep register delay of the parallel inputs, clock-enabled.
  logic [8*DW-1:0] pipe [CORE_LAT];
  always @(posedge clk) begin
    if (bus.core_ce) begin
      pipe[0] <= {bus.core_re0, bus.core_re1, bus.core_re2, bus.core_re3,
                  bus.core_im0, bus.core_im1, bus.core_im2, bus.core_im3};
      for (int i = 1; i < CORE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign {bus.core_xre0, bus.core_xre1, bus.core_xre2, bus.core_xre3,
          bus.core_xim0, bus.core_xim1, bus.core_xim2, bus.core_xim3} = pipe[CORE_LAT-1];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Behavioural model: phase 0 collecting, 1 in core flight, 2 emitting.
  int                   ph = 0, nacc = 0, cnt = 0, cpm = 0;
  logic signed [DW-1:0] sre [4];
  logic signed [DW-1:0] sim [4];
  logic signed [DW-1:0] qre [$];
  logic signed [DW-1:0] qim [$];
  logic [15:0]          scnt = '0;
  int                   obs_q [$];

  always @(negedge clk) begin
    if (rst) begin
      ph = 0; nacc = 0; cnt = 0; scnt = '0;
      qre.delete(); qim.delete();
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_core_ce", bus.core_ce, 0);
      check("rst_sym_done", bus.sym_done, 0);
      check("rst_sym_cnt", bus.sym_cnt, 0);
    end else begin
      check("in_ready", bus.in_ready, (ph == 0));
      check("sym_cnt", bus.sym_cnt, scnt);
      case (ph)
        0: begin
          check("idle_out_valid", bus.out_valid, 0);
          check("idle_core_ce", bus.core_ce, 0);
          check("idle_sym_done", bus.sym_done, 0);
          if (bus.in_valid) begin
            sre[nacc] = bus.in_re;
            sim[nacc] = bus.in_im;
            nacc++;
            if (nacc == 4) begin nacc = 0; cnt = 0; ph = 1; end
          end
        end
        1: begin
          cnt++;
          if (cnt == 1) cpm = int'(bus.cp_len);
          check("flight_out_valid", bus.out_valid, 0);
          check("flight_core_ce", bus.core_ce, 1);
          check("flight_sym_done", bus.sym_done, 0);
          if (cnt == CORE_LAT + 1) begin
            for (int p = 0; p < 4 + cpm; p++) begin
              int k;
              k = (p < cpm) ? (4 - cpm + p) : (p - cpm);
              qre.push_back(sre[k]);
              qim.push_back(sim[k]);
            end
            ph = 2;
          end
        end
        default: begin
          check("drain_out_valid", bus.out_valid, 1);
          check("drain_core_ce", bus.core_ce, 0);
          check("out_re", bus.out_re, qre[0]);
          check("out_im", bus.out_im, qim[0]);
          check("sym_done", bus.sym_done, (bus.out_ready && qre.size() == 1));
          if (bus.out_ready) begin
            obs_q.push_back(int'(bus.out_re));
            void'(qre.pop_front());
            void'(qim.pop_front());
            if (qre.size() == 0) begin scnt = scnt + 16'd1; ph = 0; end
          end
        end
      endcase
    end
  end

  task automatic send(input int re, input int im);
    bit acc;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_re    = DW'(re);
    bus.in_im    = DW'(im);
    do begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    bus.in_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    int n;
    n = 0;
    do begin @(negedge clk); ok = bus.in_ready; n++; end while (!ok && n < 300);
    if (!ok) check("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 100);
    if (!bus.out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic check_log(input string name, input int exp [7], input int len);
    check({name, "_len"}, obs_q.size(), len);
    for (int i = 0; i < len; i++)
      if (i < obs_q.size()) check(name, obs_q[i], exp[i]);
  endtask

  initial begin
    int  lat;
    bit  acc;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b1;
    bus.cp_len    = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_core_re0", bus.core_re0, 0);
    check("rst_out_re", bus.out_re, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Plain symbol, no prefix; pin first-output latency.
    obs_q.delete();
    for (int k = 1; k <= 4; k++) send(k, -k);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 50);
    check("latency", lat, CORE_LAT + 2);
    wait_idle();
    check_log("seq_cp0", '{1, 2, 3, 4, 0, 0, 0}, 4);
    check("sym_cnt_after1", bus.sym_cnt, 1);

    obs_q.delete();
    bus.cp_len = 2'd2;
    for (int k = 1; k <= 4; k++) send(k, -k);
    wait_idle();
    check_log("seq_cp2", '{3, 4, 1, 2, 3, 4, 0}, 6);

    // cp_len changed during the core flight must not affect the symbol.
    obs_q.delete();
    bus.cp_len = 2'd3;
    for (int k = 1; k <= 4; k++) send(k, -k);
    @(posedge clk); #1;
    bus.cp_len = 2'd0;
    wait_idle();
    check_log("seq_cp3", '{2, 3, 4, 1, 2, 3, 4}, 7);

    // Backpressure 1,0,0,1 during drain.
    obs_q.delete();
    for (int k = 9; k <= 12; k++) send(k, -k);
    wait_ov();
    @(posedge clk); #1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; bus.out_ready = 1'b1;
    wait_idle();
    check_log("seq_stall", '{9, 10, 11, 12, 0, 0, 0}, 4);

    // Partial symbol retained across an idle gap.
    obs_q.delete();
    send(21, 1); send(22, 2);
    repeat (10) begin @(posedge clk); #1; end
    send(23, 3); send(24, 4);
    wait_idle();
    check_log("seq_gap", '{21, 22, 23, 24, 0, 0, 0}, 4);

    // Reset in the third drain cycle.
    bus.cp_len = 2'd1;
    for (int k = 1; k <= 4; k++) send(k * 3, k);
    wait_ov();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cp_len = 2'd0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_sym_cnt", bus.sym_cnt, 0);
    check("post_rst_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    obs_q.delete();
    for (int k = 5; k <= 8; k++) send(k, k);
    wait_idle();
    check_log("seq_after_rst", '{5, 6, 7, 8, 0, 0, 0}, 4);
    check("sym_cnt_after_rst", bus.sym_cnt, 1);

    // Randomized traffic: random gaps, data, prefix and backpressure.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc || !bus.in_valid) begin
        bus.in_valid = ($urandom_range(3) != 0);
        bus.in_re    = DW'($urandom);
        bus.in_im    = DW'($urandom);
      end
      bus.out_ready = ($urandom_range(2) != 0);
      bus.cp_len    = 2'($urandom);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
